// File: rtl/apa102_frame_tx.sv
// rtl/apa102_frame_tx.sv - APA102 frame serializer: start frame, one LED frame per pixel, end frame, SPI mode 0
module apa102_frame_tx #(
    parameter int         NUM_LEDS   = 60,
    parameter int         CLK_DIV    = 4,
    parameter logic [4:0] BRIGHTNESS = 5'd31
) (
    input  logic        CLK,
    input  logic        my_reset_n,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [23:0] pix_rgb,
    output logic        pix_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        mosi,
    output logic        sck
);
    localparam int HW       = $clog2(CLK_DIV) + 1;
    localparam int CW       = $clog2(NUM_LEDS + 1);
    localparam int END_BITS = (NUM_LEDS <= 64) ? 32 : 8 * ((NUM_LEDS + 15) / 16);
    localparam int EW       = $clog2(END_BITS);

    localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
    localparam logic [CW-1:0] N_LEDS = CW'(NUM_LEDS);
    localparam logic [EW-1:0] E_LAST = EW'(END_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        FETCH,
        PIXEL,
        END
    } state_t;

    state_t        state, state_d;
    logic [HW-1:0] hcnt, hcnt_d;
    logic          phase, phase_d;
    logic [4:0]    bit_cnt, bit_d;
    logic [EW-1:0] end_cnt, end_d;
    logic [CW-1:0] pix_cnt, cnt_d;
    logic [31:0]   shreg, shreg_d;
    logic          sck_d;
    logic          done_d;
    logic          cell_end;
    logic [CW-1:0] cnt_inc;
    logic [31:0]   led_word;

    // mosi is the MSB of the shift register, so it stays a clean flop output
    assign mosi      = shreg[31];
    assign pix_ready = (state == FETCH);
    assign busy      = (state != IDLE);
    assign cnt_inc   = pix_cnt + 1'b1;
    assign led_word  = {3'b111, BRIGHTNESS, pix_rgb[7:0], pix_rgb[15:8], pix_rgb[23:16]};

    always_ff @(posedge CLK or negedge my_reset_n) begin
        if (!my_reset_n) begin
            state      <= IDLE;
            hcnt       <= '0;
            phase      <= 1'b0;
            bit_cnt    <= '0;
            end_cnt    <= '0;
            pix_cnt    <= '0;
            shreg      <= '0;
            sck        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            hcnt       <= hcnt_d;
            phase      <= phase_d;
            bit_cnt    <= bit_d;
            end_cnt    <= end_d;
            pix_cnt    <= cnt_d;
            shreg      <= shreg_d;
            sck        <= sck_d;
            frame_done <= done_d;
        end
    end

    always_comb begin
        state_d  = state;
        hcnt_d   = hcnt;
        phase_d  = phase;
        bit_d    = bit_cnt;
        end_d    = end_cnt;
        cnt_d    = pix_cnt;
        shreg_d  = shreg;
        sck_d    = sck;
        done_d   = 1'b0;
        cell_end = 1'b0;

        // Bit-cell timing: low half first (data changes there), then high half
        if (state == START || state == PIXEL || state == END) begin
            if (hcnt == H_LAST) begin
                hcnt_d   = '0;
                phase_d  = ~phase;
                sck_d    = ~phase;
                cell_end = phase;
            end else begin
                hcnt_d = hcnt + 1'b1;
            end
        end

        case (state)
            IDLE: begin
                // The frame_done cycle is idle but still refuses a new request
                if (frame_start && !frame_done) begin
                    state_d = START;
                    shreg_d = '0;
                    hcnt_d  = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                    sck_d   = 1'b0;
                end
            end
            START, PIXEL: begin
                if (cell_end) begin
                    bit_d = bit_cnt + 1'b1;
                    if (bit_cnt != 5'd31) begin
                        shreg_d = {shreg[30:0], 1'b0};
                    end else if (state == START) begin
                        state_d = FETCH;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc < N_LEDS) begin
                            state_d = FETCH;
                        end else begin
                            state_d = END;
                            shreg_d = '1;
                            end_d   = '0;
                        end
                    end
                end
            end
            FETCH: begin
                // Last bit stays on mosi while upstream stalls
                if (pix_valid) begin
                    shreg_d = led_word;
                    state_d = PIXEL;
                end
            end
            END: begin
                if (cell_end) begin
                    if (end_cnt == E_LAST) begin
                        end_d   = '0;
                        cnt_d   = '0;
                        shreg_d = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        end_d = end_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_apa102_frame_tx.sv
// tb/tb_apa102_frame_tx.sv - scoreboard bench for apa102_frame_tx
`timescale 1ns/1ps
module tb_apa102_frame_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic fs_a, pv_a, ready_a, busy_a, done_a, mosi_a, sck_a;
    logic fs_b, pv_b, ready_b, busy_b, done_b, mosi_b, sck_b;
    logic [23:0] rgb_a, rgb_b;

    apa102_frame_tx #(.NUM_LEDS(2), .CLK_DIV(2), .BRIGHTNESS(5'd31)) dut_a (
        .CLK(clk), .my_reset_n(rst_n), .frame_start(fs_a), .pix_valid(pv_a),
        .pix_rgb(rgb_a), .pix_ready(ready_a), .busy(busy_a), .frame_done(done_a),
        .mosi(mosi_a), .sck(sck_a)
    );

    apa102_frame_tx #(.NUM_LEDS(100), .CLK_DIV(1), .BRIGHTNESS(5'd3)) dut_b (
        .CLK(clk), .my_reset_n(rst_n), .frame_start(fs_b), .pix_valid(pv_b),
        .pix_rgb(rgb_b), .pix_ready(ready_b), .busy(busy_b), .frame_done(done_b),
        .mosi(mosi_b), .sck(sck_b)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    logic [31:0] acc_a = '0, acc_b = '0;
    int nb_a = 0, nb_b = 0, rise_a = 0, rise_b = 0;
    logic sq_a = 1'b0, sq_b = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sq_a = 1'b0;
            nb_a = 0;
            exp_a.delete();
        end else begin
            if (sck_a && !sq_a) begin
                rise_a++;
                acc_a = {acc_a[30:0], mosi_a};
                nb_a++;
                if (nb_a == 32) begin
                    nb_a = 0;
                    check("a_word_queued", 32'(exp_a.size() > 0), 32'd1);
                    if (exp_a.size() > 0) check("a_word", acc_a, exp_a.pop_front());
                end
            end
            sq_a = sck_a;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            sq_b = 1'b0;
            nb_b = 0;
            exp_b.delete();
        end else begin
            if (sck_b && !sq_b) begin
                rise_b++;
                acc_b = {acc_b[30:0], mosi_b};
                nb_b++;
                if (nb_b == 32) begin
                    nb_b = 0;
                    check("b_word_queued", 32'(exp_b.size() > 0), 32'd1);
                    if (exp_b.size() > 0) check("b_word", acc_b, exp_b.pop_front());
                end
            end
            sq_b = sck_b;
        end
    end

    task automatic frame_a(input int stall, input bit pulse_mid, input bit keep, output int len);
        int t0, r0, g;
        @(negedge clk);
        check("a_idle_before_start", 32'(busy_a), 32'd0);
        t0 = cyc;
        r0 = rise_a;
        fs_a = 1'b1;
        pv_a = 1'b1;
        rgb_a = 24'hFF0000;
        exp_a.push_back(32'h0);
        @(negedge clk);
        if (!keep) fs_a = 1'b0;
        check("a_busy_after_start", 32'(busy_a), 32'd1);
        check("a_sck_low_c1", 32'(sck_a), 32'd0);
        @(negedge clk);
        check("a_sck_low_c2", 32'(sck_a), 32'd0);
        @(negedge clk);
        check("a_sck_rise_c3", 32'(sck_a), 32'd1);
        for (int i = 0; i < 2; i++) begin
            exp_a.push_back(i == 0 ? 32'hFF0000FF : 32'hFF80FF00);
            rgb_a = (i == 0) ? 24'hFF0000 : 24'h00FF80;
            pv_a = !(i == 1 && stall > 0);
            g = 0;
            while (!ready_a && g < 1000) begin
                @(negedge clk);
                g++;
            end
            check("a_fetch_reached", 32'(ready_a), 32'd1);
            if (i == 1 && stall > 0) begin
                int bad;
                bad = 0;
                for (int k = 0; k < stall; k++) begin
                    if (sck_a !== 1'b0 || ready_a !== 1'b1) bad++;
                    @(negedge clk);
                end
                check("a_stall_hold", bad, 0);
                pv_a = 1'b1;
            end
            @(negedge clk);
            if (i == 0 && pulse_mid) begin
                fs_a = 1'b1;
                @(negedge clk);
                fs_a = 1'b0;
            end
        end
        rgb_a = 24'h123456;
        pv_a = 1'b0;
        exp_a.push_back(32'hFFFFFFFF);
        g = 0;
        while (!done_a && g < 3000) begin
            @(negedge clk);
            g++;
        end
        len = cyc - t0;
        check("a_done_seen", 32'(done_a), 32'd1);
        check("a_busy_low_at_done", 32'(busy_a), 32'd0);
        check("a_sck_rises", rise_a - r0, 128);
        check("a_tail_bits", nb_a, 0);
        check("a_words_left", exp_a.size(), 0);
        if (pulse_mid) begin
            fs_a = 1'b1;
            @(negedge clk);
            fs_a = 1'b0;
            check("a_done_one_cycle", 32'(done_a), 32'd0);
            check("a_done_start_ignored", 32'(busy_a), 32'd0);
            @(negedge clk);
            check("a_still_idle", 32'(busy_a), 32'd0);
        end
    endtask

    task automatic frame_b();
        int r0, g;
        logic [23:0] px;
        @(negedge clk);
        r0 = rise_b;
        fs_b = 1'b1;
        pv_b = 1'b1;
        exp_b.push_back(32'h0);
        @(negedge clk);
        fs_b = 1'b0;
        check("b_sck_p0", 32'(sck_b), 32'd0);
        @(negedge clk);
        check("b_sck_p1", 32'(sck_b), 32'd1);
        @(negedge clk);
        check("b_sck_p2", 32'(sck_b), 32'd0);
        @(negedge clk);
        check("b_sck_p3", 32'(sck_b), 32'd1);
        for (int i = 0; i < 100; i++) begin
            px = 24'($urandom);
            rgb_b = px;
            exp_b.push_back({8'hE3, px[7:0], px[15:8], px[23:16]});
            g = 0;
            while (!ready_b && g < 1000) begin
                @(negedge clk);
                g++;
            end
            check("b_fetch_reached", 32'(ready_b), 32'd1);
            @(negedge clk);
        end
        pv_b = 1'b0;
        exp_b.push_back(32'hFFFFFFFF);
        g = 0;
        while (!done_b && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("b_done_seen", 32'(done_b), 32'd1);
        check("b_sck_rises", rise_b - r0, 3288);
        check("b_end_tail_bits", nb_b, 24);
        check("b_end_tail_ones", {8'h0, acc_b[23:0]}, 32'h00FFFFFF);
        check("b_words_left", exp_b.size(), 0);
    endtask

    initial begin
        int len, g, bad;
        fs_a = 1'b1; fs_b = 1'b1; pv_a = 1'b0; pv_b = 1'b0;
        rgb_a = '0; rgb_b = '0;
        rst_n = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if ({sck_a, mosi_a, busy_a, ready_a, done_a, sck_b, mosi_b, busy_b, ready_b, done_b} !== '0) bad++;
        end
        check("reset_outputs_low", bad, 0);
        check("reset_no_sck_a", rise_a, 0);
        check("reset_no_sck_b", rise_b, 0);
        fs_a = 1'b0; fs_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        frame_a(0, 1'b0, 1'b0, len);
        check("a_len_plain", len, 515);
        frame_a(50, 1'b0, 1'b0, len);
        check("a_len_stall", len, 565);
        frame_a(0, 1'b1, 1'b0, len);
        check("a_len_pulsed", len, 515);
        frame_a(0, 1'b0, 1'b1, len);
        check("a_len_tied_1", len, 515);
        frame_a(0, 1'b0, 1'b1, len);
        check("a_len_tied_2", len, 515);
        fs_a = 1'b0;

        @(negedge clk);
        fs_a = 1'b1; pv_a = 1'b1; rgb_a = 24'hFF0000;
        exp_a.push_back(32'h0);
        @(negedge clk);
        fs_a = 1'b0;
        g = 0;
        while (!ready_a && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check("rst_fetch_reached", 32'(ready_a), 32'd1);
        repeat (3) @(negedge clk);
        check("rst_pre_sck", 32'(sck_a), 32'd1);
        check("rst_pre_mosi", 32'(mosi_a), 32'd1);
        check("rst_pre_busy", 32'(busy_a), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_sck", 32'(sck_a), 32'd0);
        check("rst_async_mosi", 32'(mosi_a), 32'd0);
        check("rst_async_busy", 32'(busy_a), 32'd0);
        pv_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        frame_b();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got time %0t expected completion before it", $time);
        $fatal(1);
    end
endmodule

// File: doc/apa102_frame_tx.md
# apa102_frame_tx

Serializes one APA102 LED-strip frame per request: 32-bit start frame, one 32-bit LED frame per pixel, then an end frame of ones, driven on `mosi`/`sck` as SPI mode 0. It sits directly downstream of the rainbow colour generator and pulls pixels from it through a valid/ready handshake. Its `mosi`/`sck` outputs are the strip pins exported by `top`.

## Interface
- `NUM_LEDS`, 60: pixels per frame; must be ≥1.
- `CLK_DIV`, 4: `CLK` cycles per `sck` half-period; must be ≥1.
- `BRIGHTNESS`, 5'd31: global brightness field sent in every LED frame.
- `CLK`  in  1  system clock; all logic on the rising edge.
- `my_reset_n`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  request a frame; sampled only in IDLE.
- `pix_valid`  in  1  upstream pixel valid.
- `pix_rgb`  in  24  pixel colour: R[23:16], G[15:8], B[7:0].
- `pix_ready`  out  1  block accepts a pixel this cycle.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse when the frame completes.
- `mosi`  out  1  serial data to the strip, MSB first.
- `sck`  out  1  serial clock to the strip; idles low.

## Operation
- States: IDLE, START, FETCH, PIXEL, END.
- IDLE -> START when `frame_start`=1. In every other state `frame_start` is ignored.
- START: shift 32 zero bits, then go to FETCH.
- FETCH: `pix_ready`=1, driven combinationally from the state.
  - On `pix_valid`&`pix_ready`, capture the word {3'b111, BRIGHTNESS, B, G, R} and go to PIXEL.
  - Without `pix_valid`, stay in FETCH indefinitely. `sck` is held low and `mosi` holds its value.
- PIXEL: shift the 32-bit word.
  - Then increment the pixel counter, width clog2(NUM_LEDS+1).
  - Go to FETCH if the count is < NUM_LEDS, else go to END.
- END: shift E one-bits, where E = 32 if NUM_LEDS ≤ 64, else 8·ceil(NUM_LEDS/16).
  - Then pulse `frame_done` for one cycle, clear the counter, and return to IDLE.
- `busy`=1 in every state except IDLE.
- Bit cell, 2·CLK_DIV cycles:
  - First CLK_DIV cycles: `sck`=0, with `mosi` updated on the first cycle of the cell.
  - Last CLK_DIV cycles: `sck`=1.
  - This keeps data stable across each rising edge (mode 0).
- The half-period counter is width clog2(CLK_DIV)+1. It wraps to 0 at CLK_DIV-1 and toggles the phase.
- The 5-bit bit counter wraps at 31 per 32-bit word. END uses its own counter sized for E.

## Timing
- Reset (async assert, synchronous deassert release is the integrator's concern):
  - Outputs: `sck`=0, `mosi`=0, `busy`=0, `pix_ready`=0, `frame_done`=0.
  - Internal: state IDLE, all counters 0.
- Reset mid-frame aborts immediately. The strip sees a truncated frame, and the next frame's start frame resynchronises it.
- `frame_start` at edge t: `busy`=1 from t+1. The first start bit is driven from t+1, and the first `sck` rise is at t+1+CLK_DIV.
- FETCH lasts ≥1 cycle per pixel. With `pix_valid` held high, each pixel costs exactly one extra cycle.
- Unstalled frame length from `frame_start` to `frame_done` = (64 + 32·NUM_LEDS)·2·CLK_DIV + NUM_LEDS + 1 cycles (NUM_LEDS ≤ 64).
- `frame_done` is asserted in the cycle after the last `sck`-high phase ends, with `busy`=0 in that same cycle.
- `frame_start` asserted in the same cycle as `frame_done` is ignored. A new request is accepted from the next cycle.
- `pix_rgb` is sampled only on the accept cycle. Later changes have no effect on the word being shifted.

## Test plan
- Reset: hold `my_reset_n`=0 with `frame_start`=1 -> all outputs 0 and no `sck` edges. Assert reset mid-PIXEL -> `sck`/`mosi`/`busy` go to 0 without waiting for a `CLK` edge.
- NUM_LEDS=2, CLK_DIV=2, `pix_valid`=1, pixels 24'hFF0000 then 24'h00FF80:
  - 128 `sck` rises in total.
  - Bits sampled on the rises = 32'h0, 32'hFF0000FF, 32'hFF80FF00, 32'hFFFFFFFF.
  - `frame_done` arrives exactly 515 cycles after `frame_start`.
- Stall: hold `pix_valid`=0 for 50 cycles at the second FETCH -> `sck` stays low and `pix_ready`=1 throughout. The serial data is identical to the unstalled case, and the frame is 50 cycles longer.
- `frame_start` pulsed while `busy` and again in the `frame_done` cycle -> exactly one frame is produced. A pulse one cycle later starts a second frame.
- CLK_DIV=1, BRIGHTNESS=5'd3, NUM_LEDS=1 -> `sck` period is 2 cycles and the LED word is 32'hE3xxxxxx. NUM_LEDS=100 -> END sends 56 ones.
- Back-to-back frames, `frame_start` tied high -> frames repeat, separated by exactly one IDLE cycle. The pixel count restarts at 0 each frame.
